pll_cfg_master: RTL and testbench
=================================

# pll_cfg_master

Avalon-MM initiator that configures and supervises the reconfigurable-PLL control/status slave. On a start pulse it waits for the PLL's reset request to clear, writes a control word to the slave's control register, reads it back for verification, then polls the status register until the lock bit is set or a timeout expires. It sits in the system-control domain between the boot sequencer and the PLL slave port.

## Interface
Parameters:
- READ_LATENCY, 0: cycles between the read-strobe edge and the readdata sample edge. 0 means sample on the same edge.
- POLL_LIMIT, 1023: maximum status reads before timeout. Range 1..65535.
- LOCK_BIT, 0: status-register bit index that indicates lock.

Ports:
- clk  in  1  system clock
- areset_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle request; ignored unless busy=0
- ctrl_word  in  16  value to program; captured on an accepted start
- busy  out  1  high from an accepted start until done/error
- done  out  1  one-cycle pulse on success
- error  out  1  one-cycle pulse on failure
- err_code  out  2  00 none, 01 readback mismatch, 10 lock timeout; held until the next start
- last_status  out  16  last status word read
- pll_resetrequest  in  1  from slave; high = slave not ready
- m_address  out  3  slave address
- m_chipselect, m_read, m_write  out  1  Avalon strobes
- m_writedata  out  16  write data
- m_readdata  in  16  read data

## Operation
- Reset values: busy=0, done=0, error=0, err_code=00, last_status=0, all m_* outputs=0. State=IDLE.
- IDLE:
  - start=1 captures ctrl_word into cw_q, clears err_code and poll_cnt, then moves to WAIT_RDY.
  - start while busy=1 is ignored.
- WAIT_RDY: remain while pll_resetrequest=1; otherwise go to WRITE. No timeout applies here.
- WRITE: one cycle with m_chipselect=1, m_write=1, m_address=3'b001, m_writedata=cw_q, then go to RB.
- RB: one cycle with m_chipselect=1, m_read=1, m_address=3'b001, then go to RB_WAIT.
- RB_WAIT:
  - Count READ_LATENCY cycles, then sample m_readdata.
  - The sample must equal cw_q; the slave returns the logical value written.
  - Match goes to POLL. Mismatch sets err_code=01 and goes to FAIL.
- POLL: one cycle with m_chipselect=1, m_read=1, m_address=3'b000, then go to POLL_WAIT.
- POLL_WAIT:
  - After READ_LATENCY cycles, load last_status=m_readdata and increment poll_cnt (16 bits, saturating).
  - Bit LOCK_BIT set goes to OK.
  - Otherwise, if poll_cnt reaches POLL_LIMIT, set err_code=10 and go to FAIL.
  - Otherwise return to POLL.
- OK: done=1 for one cycle, busy=0, go to IDLE.
- FAIL: error=1 for one cycle, busy=0, go to IDLE.
- Strobe rules:
  - At most one of m_read and m_write is asserted in any cycle.
  - m_chipselect is high only together with a strobe.
  - m_address and m_writedata are 0 when no strobe is active.
- pll_resetrequest rising while in the RB through POLL_WAIT states aborts the sequence and returns to WAIT_RDY with cw_q retained. The whole sequence then restarts from WRITE. poll_cnt clears.
- areset_n assertion mid-sequence clears all state and outputs asynchronously. No pending strobe completes.

## Timing
- All outputs are registered. Strobes are exactly one clock wide.
- Minimum start-to-done latency with READ_LATENCY=0, pll_resetrequest=0, and lock on the first poll: start edge, WAIT_RDY, WRITE, RB, RB_WAIT, POLL, POLL_WAIT, OK. done is high in cycle 7 after the start edge.
- Each poll iteration takes 2+READ_LATENCY cycles.
- done and error are never high in the same cycle. busy falls in the same cycle that done or error is high.
- A start in the same cycle as done/error is ignored, because busy is still considered 1 until the following edge.

## Structure
- Shared package pll_cfg_pkg holds:
  - state encoding constants.
  - the address constants PLL_ADDR_STATUS=3'b000 and PLL_ADDR_CTRL=3'b001.
  - the err_code constants.
- No sub-module: a single FSM with a latency counter and a poll counter.
- The latency counter is $clog2(READ_LATENCY+1) bits wide, minimum 1.

## Test plan
- Nominal case: READ_LATENCY=0, ctrl_word=16'hA5A6, slave model locks on the 3rd poll.
  - Expect one write to address 1 with data A5A6, a readback of A5A6, and 3 status reads.
  - Expect done on cycle 11 and err_code=00.
- Mismatch: the model corrupts readback to A5A4 -> error pulse, err_code=01, no status reads issued.
- Timeout: POLL_LIMIT=4, status never locks -> exactly 4 status reads, then error with err_code=10 and last_status=0.
- Reset-request hold: pll_resetrequest=1 for 64 cycles after start -> no strobes during those 64 cycles, then the write occurs one cycle after release.
- Abort: pll_resetrequest pulses during POLL_WAIT -> the FSM returns to WAIT_RDY, then a second write of the same cw_q follows, and the sequence completes with done.
- Reset and latency: areset_n asserted mid-POLL -> all outputs 0 immediately. With READ_LATENCY=2, readdata is sampled exactly 2 edges after the strobe (check with a late-valid slave model).

Source files
------------

// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module : pll_cfg_pkg
// Brief  : Shared state encoding, slave register map and error codes for
//          the PLL configuration master.
// Rev    : 1.0
// ============================================================================
package pll_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_RDY  = 4'd1,
    ST_WRITE     = 4'd2,
    ST_RB        = 4'd3,
    ST_RB_WAIT   = 4'd4,
    ST_POLL      = 4'd5,
    ST_POLL_WAIT = 4'd6,
    ST_OK        = 4'd7,
    ST_FAIL      = 4'd8
  } pll_state_e;

  localparam logic [2:0] PLL_ADDR_STATUS = 3'b000;
  localparam logic [2:0] PLL_ADDR_CTRL   = 3'b001;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_cfg_master.sv
`default_nettype none
// ============================================================================
// Module : pll_cfg_master
// Brief  : Avalon-MM initiator that programs the PLL control register,
//          verifies it by readback and polls status until lock or timeout.
// Rev    : 1.0
// ============================================================================
module pll_cfg_master
  import pll_cfg_pkg::*;
#(
  parameter int READ_LATENCY = 0,
  parameter int POLL_LIMIT   = 1023,
  parameter int LOCK_BIT     = 0
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        start,
  input  logic [15:0] ctrl_word,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] last_status,
  input  logic        pll_resetrequest,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata
);

  localparam int              LAT_W    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0] LAT_PRE  = (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;
  localparam logic [15:0]      POLL_MAX = 16'(POLL_LIMIT);

  pll_state_e       state;
  logic [15:0]      cw_q;
  logic [15:0]      poll_cnt;
  logic [15:0]      poll_nxt;
  logic [15:0]      samp;
  logic [LAT_W-1:0] lat_cnt;
  logic             capture;
  logic             abort;
  logic             wait_done;

  // Read data is captured exactly READ_LATENCY edges after the strobe edge;
  // the decision is taken one cycle later from the captured copy.
  always_comb begin
    capture = 1'b0;
    if (READ_LATENCY == 0)
      capture = (state == ST_RB) || (state == ST_POLL);
    else
      capture = ((state == ST_RB_WAIT) || (state == ST_POLL_WAIT)) && (lat_cnt == LAT_PRE);
  end

  assign abort     = pll_resetrequest &&
                     ((state == ST_RB) || (state == ST_RB_WAIT) ||
                      (state == ST_POLL) || (state == ST_POLL_WAIT));
  assign wait_done = (lat_cnt == LAT_LAST);
  assign poll_nxt  = sat_inc16(poll_cnt);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      last_status  <= '0;
      m_address    <= PLL_ADDR_STATUS;
      m_chipselect <= 1'b0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      cw_q         <= '0;
      poll_cnt     <= '0;
      samp         <= '0;
      lat_cnt      <= '0;
    end else begin
      done         <= 1'b0;
      error        <= 1'b0;
      m_chipselect <= 1'b0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= PLL_ADDR_STATUS;
      m_writedata  <= '0;
      if (capture)
        samp <= m_readdata;

      if (abort) begin
        state    <= ST_WAIT_RDY;
        poll_cnt <= '0;
        lat_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cw_q     <= ctrl_word;
              err_code <= ERR_NONE;
              poll_cnt <= '0;
              busy     <= 1'b1;
              state    <= ST_WAIT_RDY;
            end
          end
          ST_WAIT_RDY: begin
            if (!pll_resetrequest) begin
              state        <= ST_WRITE;
              m_chipselect <= 1'b1;
              m_write      <= 1'b1;
              m_address    <= PLL_ADDR_CTRL;
              m_writedata  <= cw_q;
            end
          end
          ST_WRITE: begin
            state        <= ST_RB;
            m_chipselect <= 1'b1;
            m_read       <= 1'b1;
            m_address    <= PLL_ADDR_CTRL;
          end
          ST_RB: begin
            state   <= ST_RB_WAIT;
            lat_cnt <= '0;
          end
          ST_RB_WAIT: begin
            if (!wait_done) begin
              lat_cnt <= lat_cnt + 1'b1;
            end else if (samp == cw_q) begin
              state        <= ST_POLL;
              m_chipselect <= 1'b1;
              m_read       <= 1'b1;
              m_address    <= PLL_ADDR_STATUS;
            end else begin
              err_code <= ERR_MISMATCH;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_FAIL;
            end
          end
          ST_POLL: begin
            state   <= ST_POLL_WAIT;
            lat_cnt <= '0;
          end
          ST_POLL_WAIT: begin
            if (!wait_done) begin
              lat_cnt <= lat_cnt + 1'b1;
            end else begin
              last_status <= samp;
              poll_cnt    <= poll_nxt;
              if (samp[LOCK_BIT]) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_OK;
              end else if (poll_nxt >= POLL_MAX) begin
                err_code <= ERR_TIMEOUT;
                error    <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_FAIL;
              end else begin
                state        <= ST_POLL;
                m_chipselect <= 1'b1;
                m_read       <= 1'b1;
                m_address    <= PLL_ADDR_STATUS;
              end
            end
          end
          ST_OK, ST_FAIL: state <= ST_IDLE;
          default:        state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_cfg_master.sv
`default_nettype none
// ============================================================================
// Module : tb_pll_cfg_master
// Brief  : Cycle-timeline model and slave models around two configurations
//          of pll_cfg_master (zero and two-cycle read latency).
// Rev    : 1.0
// ============================================================================
module tb_pll_cfg_master;
  import pll_cfg_pkg::*;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        error;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset_n = 1'b0;

  logic start_a = 1'b0, rr_a = 1'b0;
  logic [15:0] cw_a = '0;
  logic a_busy, a_done, a_error, a_cs, a_rd, a_wr;
  logic [1:0] a_err;
  logic [15:0] a_last, a_wdata, a_rdata;
  logic [2:0] a_addr;

  logic start_b = 1'b0, rr_b = 1'b0;
  logic [15:0] cw_b = '0;
  logic b_busy, b_done, b_error, b_cs, b_rd, b_wr;
  logic [1:0] b_err;
  logic [15:0] b_last, b_wdata, b_rdata;
  logic [2:0] b_addr;

  pll_cfg_master #(.READ_LATENCY(0), .POLL_LIMIT(4), .LOCK_BIT(0)) dut_a (
    .clk(clk), .areset_n(areset_n), .start(start_a), .ctrl_word(cw_a),
    .busy(a_busy), .done(a_done), .error(a_error), .err_code(a_err),
    .last_status(a_last), .pll_resetrequest(rr_a), .m_address(a_addr),
    .m_chipselect(a_cs), .m_read(a_rd), .m_write(a_wr),
    .m_writedata(a_wdata), .m_readdata(a_rdata));

  pll_cfg_master #(.READ_LATENCY(2), .POLL_LIMIT(8), .LOCK_BIT(3)) dut_b (
    .clk(clk), .areset_n(areset_n), .start(start_b), .ctrl_word(cw_b),
    .busy(b_busy), .done(b_done), .error(b_error), .err_code(b_err),
    .last_status(b_last), .pll_resetrequest(rr_b), .m_address(b_addr),
    .m_chipselect(b_cs), .m_read(b_rd), .m_write(b_wr),
    .m_writedata(b_wdata), .m_readdata(b_rdata));

  int checks = 0;
  int failures = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, wr_cyc = 0;
  int a_writes = 0, a_stat_reads = 0, a_polls = 0, lock_on = 0;
  bit corrupt = 1'b0;
  bit sel = 1'b0;
  logic [15:0] a_ctrl = '0, a_last_wdata = '0;
  logic [15:0] b_ctrl = '0;
  int b_polls = 0;
  logic b_p1 = 1'b0, b_p2 = 1'b0;
  logic [2:0] b_a1 = '0, b_a2 = '0;
  cyc_t q[$];
  cyc_t obs, exp_c;

  assign obs = sel ? {b_busy, b_done, b_error, b_cs, b_rd, b_wr, b_addr, b_wdata}
                   : {a_busy, a_done, a_error, a_cs, a_rd, a_wr, a_addr, a_wdata};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Slave A: zero-latency, readdata valid during the strobe cycle.
  always_comb begin
    a_rdata = 16'h0000;
    if (a_cs && a_rd) begin
      if (a_addr == PLL_ADDR_CTRL)
        a_rdata = a_ctrl ^ (corrupt ? 16'h0002 : 16'h0000);
      else if (a_addr == PLL_ADDR_STATUS)
        a_rdata = (lock_on != 0 && a_polls + 1 >= lock_on) ? 16'h8001 : 16'h0000;
    end
  end

  always @(posedge clk) begin
    if (a_cs && a_wr && a_addr == PLL_ADDR_CTRL) begin
      a_ctrl       <= a_wdata;
      a_polls      <= 0;
      a_writes     <= a_writes + 1;
      a_last_wdata <= a_wdata;
    end
    if (a_cs && a_rd && a_addr == PLL_ADDR_STATUS) begin
      a_polls      <= a_polls + 1;
      a_stat_reads <= a_stat_reads + 1;
    end
  end

  // Slave B: data valid only in the cycle ending at the second edge after the strobe.
  always_comb begin
    b_rdata = 16'hDEAD;
    if (b_p2)
      b_rdata = (b_a2 == PLL_ADDR_CTRL) ? b_ctrl : ((b_polls + 1 >= 2) ? 16'h0008 : 16'h0000);
  end

  always @(posedge clk) begin
    b_p1 <= b_cs && b_rd;
    b_a1 <= b_addr;
    b_p2 <= b_p1;
    b_a2 <= b_a1;
    if (b_cs && b_wr && b_addr == PLL_ADDR_CTRL) begin
      b_ctrl  <= b_wdata;
      b_polls <= 0;
    end else if (b_p2 && b_a2 == PLL_ADDR_STATUS) begin
      b_polls <= b_polls + 1;
    end
  end

  // Cycle numbering: the values recorded here name the cycle that just ended.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (obs.done) done_cyc <= cyc;
    if (obs.cs && obs.wr) wr_cyc <= cyc;
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_c = q.pop_front();
      chk("cycle_model", 32'(obs), 32'(exp_c));
    end
  end

  task automatic push(input logic b, input logic d, input logic e, input logic cs,
                      input logic rd, input logic wr, input logic [2:0] ad, input logic [15:0] wd);
    q.push_back({b, d, e, cs, rd, wr, ad, wd});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, 0, 3'b000, 16'h0000);
  endtask

  // Expected per-cycle outputs derived from the sequence description.
  task automatic model_run(input int hold, input int lat, input logic [15:0] cw, input bit rb_ok,
                           input int polls, input int abort_at, input bit locks);
    for (int i = 0; i < 1 + hold; i++) push(1, 0, 0, 0, 0, 0, 3'b000, 16'h0000);
    push(1, 0, 0, 1, 0, 1, 3'b001, cw);
    push(1, 0, 0, 1, 1, 0, 3'b001, 16'h0000);
    for (int i = 0; i <= lat; i++) push(1, 0, 0, 0, 0, 0, 3'b000, 16'h0000);
    if (!rb_ok) begin
      push(0, 0, 1, 0, 0, 0, 3'b000, 16'h0000);
      return;
    end
    for (int p = 1; p <= polls; p++) begin
      push(1, 0, 0, 1, 1, 0, 3'b000, 16'h0000);
      for (int i = 0; i <= lat; i++) push(1, 0, 0, 0, 0, 0, 3'b000, 16'h0000);
      if (p == abort_at) return;
    end
    push(0, locks, !locks, 0, 0, 0, 3'b000, 16'h0000);
  endtask

  // Drives start across one edge; afterwards the current cycle is cycle 1.
  task automatic kick(input bit which, input logic [15:0] cw);
    if (which) begin start_b = 1'b1; cw_b = cw; end
    else begin start_a = 1'b1; cw_a = cw; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_cyc = cyc - 1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("model_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  int w0, s0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl_a", {24'd0, a_busy, a_done, a_error, a_err, a_cs, a_rd, a_wr, a_addr}, 32'd0);
    chk("reset_dat_a", {a_last, a_wdata}, 32'd0);
    chk("reset_ctl_b", {24'd0, b_busy, b_done, b_error, b_err, b_cs, b_rd, b_wr, b_addr}, 32'd0);
    chk("reset_dat_b", {b_last, b_wdata}, 32'd0);
    areset_n = 1'b1;
    @(posedge clk); #1;

    // Nominal: lock on the third poll; starts while busy and on the done cycle are ignored.
    sel = 1'b0; lock_on = 3; corrupt = 1'b0;
    w0 = a_writes; s0 = a_stat_reads;
    kick(1'b0, 16'hA5A6);
    model_run(0, 0, 16'hA5A6, 1, 3, 0, 1);
    push_idle(3);
    repeat (2) @(posedge clk); #1;
    start_a = 1'b1; cw_a = 16'h1234;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    drain(40);
    chk("nom_done_cycle", 32'(done_cyc - start_cyc), 32'd11);
    chk("nom_writes", 32'(a_writes - w0), 32'd1);
    chk("nom_wdata", {16'd0, a_last_wdata}, 32'h0000A5A6);
    chk("nom_status_reads", 32'(a_stat_reads - s0), 32'd3);
    chk("nom_err_code", {30'd0, a_err}, 32'd0);
    chk("nom_last_status", {16'd0, a_last}, 32'h00008001);

    // Readback mismatch.
    corrupt = 1'b1;
    s0 = a_stat_reads;
    kick(1'b0, 16'hA5A6);
    model_run(0, 0, 16'hA5A6, 0, 0, 0, 0);
    push_idle(2);
    drain(40);
    chk("mm_err_code", {30'd0, a_err}, 32'h1);
    chk("mm_status_reads", 32'(a_stat_reads - s0), 32'd0);
    corrupt = 1'b0;

    // Lock timeout after POLL_LIMIT=4 reads.
    lock_on = 0;
    s0 = a_stat_reads;
    kick(1'b0, 16'h5A5A);
    model_run(0, 0, 16'h5A5A, 1, 4, 0, 0);
    push_idle(2);
    drain(60);
    chk("to_err_code", {30'd0, a_err}, 32'h2);
    chk("to_status_reads", 32'(a_stat_reads - s0), 32'd4);
    chk("to_last_status", {16'd0, a_last}, 32'd0);

    // Reset request held for 64 cycles after start.
    lock_on = 1;
    kick(1'b0, 16'h0F0F);
    rr_a = 1'b1;
    model_run(64, 0, 16'h0F0F, 1, 1, 0, 1);
    push_idle(2);
    repeat (64) @(posedge clk); #1;
    rr_a = 1'b0;
    drain(40);
    chk("hold_write_cycle", 32'(wr_cyc - start_cyc), 32'd66);
    chk("hold_err_code", {30'd0, a_err}, 32'd0);

    // Abort by a reset-request pulse during POLL_WAIT, then full restart.
    lock_on = 2;
    w0 = a_writes;
    kick(1'b0, 16'hC3C3);
    model_run(0, 0, 16'hC3C3, 1, 1, 1, 1);
    model_run(0, 0, 16'hC3C3, 1, 2, 0, 1);
    push_idle(2);
    repeat (5) @(posedge clk); #1;
    rr_a = 1'b1;
    @(posedge clk); #1;
    rr_a = 1'b0;
    drain(60);
    chk("abort_writes", 32'(a_writes - w0), 32'd2);
    chk("abort_wdata", {16'd0, a_last_wdata}, 32'h0000C3C3);
    chk("abort_done_cycle", 32'(done_cyc - start_cyc), 32'd15);

    // Asynchronous reset while a status read strobe is on the bus.
    lock_on = 3;
    kick(1'b0, 16'h7E57);
    model_run(0, 0, 16'h7E57, 1, 3, 0, 1);
    repeat (4) @(posedge clk); #1;
    chk("rst_poll_strobe", {29'd0, a_cs, a_rd, a_addr == PLL_ADDR_STATUS}, 32'h7);
    q.delete();
    areset_n = 1'b0;
    #1;
    chk("rst_async_ctl", {24'd0, a_busy, a_done, a_error, a_err, a_cs, a_rd, a_wr, a_addr}, 32'd0);
    chk("rst_async_dat", {a_last, a_wdata}, 32'd0);
    repeat (2) @(posedge clk); #1;
    areset_n = 1'b1;
    push_idle(3);
    drain(10);

    // Two-cycle read latency against a late-valid slave.
    sel = 1'b1;
    kick(1'b1, 16'h3C3C);
    model_run(0, 2, 16'h3C3C, 1, 2, 0, 1);
    push_idle(2);
    drain(60);
    chk("lat2_done_cycle", 32'(done_cyc - start_cyc), 32'd15);
    chk("lat2_last_status", {16'd0, b_last}, 32'h00000008);
    chk("lat2_err_code", {30'd0, b_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
